// File: rtl/apb_reg_responder_if.sv
// ---------------------------------------------------------------------------
// apb_if
// APB bus bundle between a requester (src) and a completer (dst).
//   paddr   : byte address                (src -> dst)
//   psel    : select                      (src -> dst)
//   penable : access phase                (src -> dst)
//   pwrite  : 1 = write, 0 = read         (src -> dst)
//   pwdata  : write data                  (src -> dst)
//   prdata  : read data, valid with pready (dst -> src)
//   pready  : transfer completes          (dst -> src)
//   pslverr : error response              (dst -> src)
// ---------------------------------------------------------------------------
interface apb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport dst (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

    modport src (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_responder.sv
// ---------------------------------------------------------------------------
// apb_reg_responder
// APB completer holding a small register bank: ID (read-only), CTRL,
// STATUS (sticky events, write-1-to-clear), IRQ_EN and scratch words.
// Adds WAIT_STATES wait cycles per transfer and answers bad accesses with
// pslverr.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   apbReg   : APB completer port (apb_if.dst)
//   ctrl_out : CTRL register contents
//   evt_in   : per-bit event pulses, OR-ed into STATUS every cycle
//   irq      : registered |(STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
module apb_reg_responder #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA2C0_0001
) (
    input  logic              clk,
    input  logic              rst,
    apb_if.dst                apbReg,
    output logic [DATA_W-1:0] ctrl_out,
    input  logic [DATA_W-1:0] evt_in,
    output logic              irq
);

    localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * NUM_REGS);

    localparam logic [IDX_W-1:0] W_ID     = IDX_W'(0);
    localparam logic [IDX_W-1:0] W_CTRL   = IDX_W'(1);
    localparam logic [IDX_W-1:0] W_STATUS = IDX_W'(2);
    localparam logic [IDX_W-1:0] W_IRQEN  = IDX_W'(3);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            state_q;
    logic [3:0]        wcnt_q;

    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] status_d;
    logic [DATA_W-1:0] irq_en_q;
    logic              irq_q;
    // Entries 0..3 are shadowed by ID/CTRL/STATUS/IRQ_EN and never written;
    // full-size indexing keeps the word index width exact.
    logic [DATA_W-1:0] scratch_q [NUM_REGS];

    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word;
    logic              in_window;
    logic              err;
    logic              complete;
    logic              wr_ok;
    logic [DATA_W-1:0] w1c_mask;
    logic [DATA_W-1:0] rd_word;

    // ---------------- decode ----------------
    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    assign offset    = apbReg.paddr - BASE_ADDR;
    assign in_window = (apbReg.paddr >= BASE_ADDR) && (offset < WIN_BYTES);
    assign word      = offset[IDX_W+1:2];
    assign err       = !in_window || (apbReg.paddr[1:0] != 2'b00)
                     || (apbReg.pwrite && word == W_ID);

    // Completion is suppressed while rst is high so an in-flight transfer
    // neither responds nor commits.
    assign complete  = (state_q == S_ACCESS) && apbReg.psel && apbReg.penable
                     && (wcnt_q == 4'd0) && !rst;
    assign wr_ok     = complete && apbReg.pwrite && !err;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (apbReg.psel && !apbReg.penable) begin
                        state_q <= S_ACCESS;
                        wcnt_q  <= 4'(WAIT_STATES);
                    end
                end
                S_ACCESS: begin
                    if (!apbReg.psel) begin
                        state_q <= S_IDLE;          // requester abandoned the transfer
                    end else if (apbReg.penable) begin
                        if (wcnt_q != 4'd0) wcnt_q  <= wcnt_q - 4'd1;
                        else                state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- register bank ----------------
    assign w1c_mask = (wr_ok && word == W_STATUS) ? apbReg.pwdata : '0;
    // Event OR-in comes after the clear, so a simultaneous set wins.
    assign status_d = (status_q & ~w1c_mask) | evt_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            // NOTE: the scratch array is architecturally reset to zero, so it
            // is cleared element by element rather than left uninitialised.
            for (int i = 0; i < int'(NUM_REGS); i++) scratch_q[i] <= '0;
        end else begin
            status_q <= status_d;
            irq_q    <= |(status_q & irq_en_q);
            if (wr_ok) begin
                case (word)
                    W_CTRL:   ctrl_q   <= apbReg.pwdata;
                    W_STATUS: ;                           // handled by w1c_mask
                    W_IRQEN:  irq_en_q <= apbReg.pwdata;
                    default:  if (word > W_IRQEN) scratch_q[word] <= apbReg.pwdata;
                endcase
            end
        end
    end

    // ---------------- read path ----------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_word = '0;
        case (word)
            W_ID:     rd_word = ID_VALUE;
            W_CTRL:   rd_word = ctrl_q;
            W_STATUS: rd_word = status_q;
            W_IRQEN:  rd_word = irq_en_q;
            default:  if (32'(word) < NUM_REGS) rd_word = scratch_q[word];
        endcase
    end

    assign apbReg.pready  = complete;
    assign apbReg.pslverr = complete && err;
    assign apbReg.prdata  = (complete && !apbReg.pwrite && !err) ? rd_word : '0;

    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_responder
// Two responders share one APB driver: u_dut_w1 (WAIT_STATES=1) and
// u_dut_w0 (WAIT_STATES=0); use_w0 routes psel and the monitored outputs.
// Expected responses are queued when a transfer starts and compared when
// pready appears.
// ---------------------------------------------------------------------------
module tb_apb_reg_responder;

    localparam logic [31:0] BASE   = 32'h4000_1000;
    localparam logic [31:0] ID_VAL = 32'hA2C0_0001;
    localparam logic [31:0] A_ID   = BASE;
    localparam logic [31:0] A_CTRL = BASE + 32'd4;
    localparam logic [31:0] A_STAT = BASE + 32'd8;
    localparam logic [31:0] A_IEN  = BASE + 32'd12;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          chk_rd;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr, pwdata, evt_in;
    logic        psel, penable, pwrite, use_w0;
    logic [31:0] ctrl_w1, ctrl_w0;
    logic        irq_w1, irq_w0;
    logic        mon_pready, mon_pslverr;
    logic [31:0] mon_prdata;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus_w1 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus_w0 ();

    assign bus_w1.paddr   = paddr;
    assign bus_w1.psel    = psel & ~use_w0;
    assign bus_w1.penable = penable;
    assign bus_w1.pwrite  = pwrite;
    assign bus_w1.pwdata  = pwdata;
    assign bus_w0.paddr   = paddr;
    assign bus_w0.psel    = psel & use_w0;
    assign bus_w0.penable = penable;
    assign bus_w0.pwrite  = pwrite;
    assign bus_w0.pwdata  = pwdata;

    assign mon_pready  = use_w0 ? bus_w0.pready  : bus_w1.pready;
    assign mon_pslverr = use_w0 ? bus_w0.pslverr : bus_w1.pslverr;
    assign mon_prdata  = use_w0 ? bus_w0.prdata  : bus_w1.prdata;

    apb_reg_responder #(.NUM_REGS(8), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut_w1 (
        .clk      (clk),
        .rst      (rst),
        .apbReg   (bus_w1),
        .ctrl_out (ctrl_w1),
        .evt_in   (evt_in),
        .irq      (irq_w1)
    );

    apb_reg_responder #(.NUM_REGS(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut_w0 (
        .clk      (clk),
        .rst      (rst),
        .apbReg   (bus_w0),
        .ctrl_out (ctrl_w0),
        .evt_in   (evt_in),
        .irq      (irq_w0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts in the cycle after a posedge; returns just after the
    // completion edge with psel still high, so calls chain back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   waits = 0;
        bit   done  = 1'b0;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.chk_rd = !wr;
        e.waits  = use_w0 ? 0 : 1;
        exp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (mon_pready) begin
                e = exp_q.pop_front();
                check("pslverr", 32'(mon_pslverr), 32'(e.err));
                if (e.chk_rd) check("prdata", mon_prdata, e.rdata);
                check("wait_states", 32'(waits), 32'(e.waits));
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            check("pready_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        penable = 1'b0;
    endtask

    task automatic go_idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; evt_in = '0; use_w0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_pready",  32'(mon_pready),  32'd0);
        check("rst_pslverr", 32'(mon_pslverr), 32'd0);
        check("rst_prdata",  mon_prdata,       32'd0);
        check("rst_irq",     32'(irq_w1),      32'd0);
        check("rst_ctrl",    ctrl_w1,          32'd0);
        @(posedge clk); #1;

        // ID read and CTRL write/readback
        xfer(1'b0, A_ID, '0, ID_VAL, 1'b0);
        xfer(1'b1, A_CTRL, 32'hDEAD_BEEF, '0, 1'b0);
        check("ctrl_out_commit", ctrl_w1, 32'hDEAD_BEEF);
        xfer(1'b0, A_CTRL, '0, 32'hDEAD_BEEF, 1'b0);

        // error responses leave registers untouched
        xfer(1'b1, A_ID, 32'hFFFF_FFFF, '0, 1'b1);
        xfer(1'b0, A_ID, '0, ID_VAL, 1'b0);
        xfer(1'b0, BASE + 32'd32, '0, '0, 1'b1);
        xfer(1'b0, BASE - 32'd4, '0, '0, 1'b1);
        xfer(1'b1, BASE + 32'd6, 32'h1111_1111, '0, 1'b1);
        xfer(1'b0, BASE + 32'd6, '0, '0, 1'b1);
        xfer(1'b0, A_CTRL, '0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b1, BASE + 32'd16, 32'hA5A5_5A5A, '0, 1'b0);
        xfer(1'b0, BASE + 32'd16, '0, 32'hA5A5_5A5A, 1'b0);
        go_idle();

        // STATUS events, interrupt and set/clear collision
        evt_in = 32'h5;
        @(posedge clk); #1;
        evt_in = 32'h0;
        xfer(1'b1, A_IEN, 32'h1, '0, 1'b0);
        go_idle();
        check("irq_set", 32'(irq_w1), 32'd1);
        xfer(1'b0, A_STAT, '0, 32'h5, 1'b0);
        evt_in = 32'h1;
        xfer(1'b1, A_STAT, 32'h1, '0, 1'b0);
        evt_in = 32'h0;
        xfer(1'b0, A_STAT, '0, 32'h5, 1'b0);
        check("irq_collision", 32'(irq_w1), 32'd1);
        xfer(1'b1, A_STAT, 32'h5, '0, 1'b0);
        check("irq_lag", 32'(irq_w1), 32'd1);
        go_idle();
        check("irq_cleared", 32'(irq_w1), 32'd0);
        xfer(1'b0, A_STAT, '0, 32'h0, 1'b0);
        go_idle();

        // reset lands in the completion cycle of a CTRL write
        psel = 1'b1; paddr = A_CTRL; pwrite = 1'b1; pwdata = 32'h1234_5678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rst_abort_wait", 32'(mon_pready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_pready", 32'(mon_pready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("rst_abort_ctrl", ctrl_w1, 32'd0);

        // psel dropped mid-wait
        psel = 1'b1; paddr = A_CTRL; pwrite = 1'b1; pwdata = 32'h0000_0055;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_wait", 32'(mon_pready), 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_pready", 32'(mon_pready), 32'd0);
        @(posedge clk); #1;
        xfer(1'b0, A_CTRL, '0, 32'd0, 1'b0);
        xfer(1'b0, A_IEN, '0, 32'd0, 1'b0);
        go_idle();

        // zero-wait back-to-back scratch traffic
        use_w0 = 1'b1;
        for (int w = 4; w < 8; w++)
            xfer(1'b1, BASE + 32'(4 * w), 32'hC0DE_0000 + 32'(w * 17), '0, 1'b0);
        for (int w = 4; w < 8; w++)
            xfer(1'b0, BASE + 32'(4 * w), '0, 32'hC0DE_0000 + 32'(w * 17), 1'b0);
        go_idle();
        check("w0_ctrl_idle", ctrl_w0, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
